// File: rtl/halut_pkg.sv
// Shared HALUT constants and types used by the encoder bank and its controller.
package halut_pkg;

    localparam int unsigned K             = 16;
    localparam int unsigned C             = 32;
    localparam int unsigned DataTypeWidth = 16;
    localparam int unsigned EncUnits      = 4;

    // Threshold memory geometry of one encoder unit.
    localparam int unsigned ThreshDepth        = (C / EncUnits) * K;
    localparam int unsigned ThreshMemAddrWidth = $clog2(ThreshDepth);

    typedef enum logic [1:0] {
        EncIdle,
        EncLoad,
        EncRun,
        EncDone
    } enc_ctrl_state_e;

endpackage

// File: rtl/halut_thresh_loader.sv
// Threshold load datapath: counts accepted config words, splits the index into
// unit/address and drives registered per-unit write ports.
module halut_thresh_loader #(
    parameter int unsigned EncUnits    = 4,
    parameter int unsigned ThreshDepth = 128,
    parameter int unsigned AddrWidth   = 7,
    parameter int unsigned DataWidth   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 beat_i,
    input  logic [DataWidth-1:0] data_i,
    output logic                 last_o,
    output logic [AddrWidth-1:0] waddr_o [EncUnits],
    output logic [DataWidth-1:0] wdata_o [EncUnits],
    output logic                 we_o    [EncUnits]
);

    localparam int unsigned TotalWords = EncUnits * ThreshDepth;
    localparam int unsigned CntWidth   = $clog2(TotalWords);

    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [CntWidth-1:0]  unitIdx;
    logic [AddrWidth-1:0] unitAddr;

    assign unitIdx  = cnt_q / CntWidth'(ThreshDepth);
    assign unitAddr = AddrWidth'(cnt_q % CntWidth'(ThreshDepth));
    assign last_o   = beat_i && (cnt_q == CntWidth'(TotalWords - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (beat_i) begin
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Only the unit owning the current word sees a write strobe; the other
    // units keep their last address/data so idle ports do not toggle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            for (int u = 0; u < int'(EncUnits); u++) begin
                we_o[u]    <= 1'b0;
                waddr_o[u] <= '0;
                wdata_o[u] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int u = 0; u < int'(EncUnits); u++) begin
                we_o[u] <= beat_i && (unitIdx == CntWidth'(u));
                if (beat_i && (unitIdx == CntWidth'(u))) begin
                    waddr_o[u] <= unitAddr;
                    wdata_o[u] <= data_i;
                end
            end
        end
    end

endmodule

// File: rtl/halut_encoder_ctrl.sv
// HALUT encoder bank sequencer: loads all threshold memories from one config
// stream, then runs the bank for a number of rows and tags each result.
module halut_encoder_ctrl #(
    parameter int unsigned K             = halut_pkg::K,
    parameter int unsigned C             = halut_pkg::C,
    parameter int unsigned DataTypeWidth = halut_pkg::DataTypeWidth,
    parameter int unsigned EncUnits      = 4,
    parameter int unsigned RowWidth      = 16,
    localparam int unsigned CAddrWidth         = $clog2(C),
    localparam int unsigned TreeDepth          = $clog2(K),
    localparam int unsigned CPerEncUnit        = C / EncUnits,
    localparam int unsigned ThreshDepth        = CPerEncUnit * K,
    localparam int unsigned ThreshMemAddrWidth = $clog2(ThreshDepth)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          load_i,
    input  logic                          cfg_valid_i,
    output logic                          cfg_ready_o,
    input  logic [DataTypeWidth-1:0]      cfg_data_i,
    input  logic                          start_i,
    input  logic [RowWidth-1:0]           num_rows_i,
    input  logic                          abort_i,
    output logic [ThreshMemAddrWidth-1:0] waddr_o [EncUnits],
    output logic [DataTypeWidth-1:0]      wdata_o [EncUnits],
    output logic                          we_o    [EncUnits],
    output logic                          encoder_o,
    input  logic                          bank_valid_i,
    input  logic [CAddrWidth-1:0]         bank_c_addr_i,
    input  logic [TreeDepth-1:0]          bank_k_addr_i,
    output logic                          out_valid_o,
    output logic [RowWidth-1:0]           out_row_o,
    output logic [CAddrWidth-1:0]         out_c_addr_o,
    output logic [TreeDepth-1:0]          out_k_addr_o,
    output logic                          busy_o,
    output logic                          loaded_o,
    output logic                          done_o,
    output logic                          err_o
);

    import halut_pkg::*;

    enc_ctrl_state_e       state_q;
    logic                  cfg_ready_q, encoder_q, out_valid_q;
    logic                  loaded_q, done_q, err_q;
    logic [RowWidth-1:0]   row_q, num_rows_q, out_row_q;
    logic [CAddrWidth-1:0] c_q, out_c_q;
    logic [TreeDepth-1:0]  out_k_q;
    logic                  beat, loadClear, lastWord;

    // Abort also blocks the handshake so no write escapes in the abort cycle.
    assign beat      = (state_q == EncLoad) && cfg_valid_i && cfg_ready_q && !abort_i;
    assign loadClear = (state_q == EncIdle) && load_i && !abort_i;

    halut_thresh_loader #(
        .EncUnits    (EncUnits),
        .ThreshDepth (ThreshDepth),
        .AddrWidth   (ThreshMemAddrWidth),
        .DataWidth   (DataTypeWidth)
    ) u_loader (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (loadClear),
        .beat_i  (beat),
        .data_i  (cfg_data_i),
        .last_o  (lastWord),
        .waddr_o (waddr_o),
        .wdata_o (wdata_o),
        .we_o    (we_o)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= EncIdle;
            cfg_ready_q <= 1'b0;
            encoder_q   <= 1'b0;
            out_valid_q <= 1'b0;
            loaded_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            row_q       <= '0;
            num_rows_q  <= '0;
            c_q         <= '0;
            out_row_q   <= '0;
            out_c_q     <= '0;
            out_k_q     <= '0;
        end else begin
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            if (abort_i) begin
                state_q     <= EncIdle;
                cfg_ready_q <= 1'b0;
                encoder_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    EncIdle: begin
                        if (load_i) begin
                            state_q     <= EncLoad;
                            cfg_ready_q <= 1'b1;
                            loaded_q    <= 1'b0;
                            err_q       <= 1'b0;
                        end else if (start_i && loaded_q) begin
                            err_q      <= 1'b0;
                            row_q      <= '0;
                            c_q        <= '0;
                            num_rows_q <= num_rows_i;
                            if (num_rows_i == '0) begin
                                state_q <= EncDone;
                                done_q  <= 1'b1;
                            end else begin
                                state_q   <= EncRun;
                                encoder_q <= 1'b1;
                            end
                        end
                    end
                    EncLoad: begin
                        if (lastWord) begin
                            state_q     <= EncIdle;
                            cfg_ready_q <= 1'b0;
                            loaded_q    <= 1'b1;
                        end
                    end
                    EncRun: begin
                        if (bank_valid_i) begin
                            out_valid_q <= 1'b1;
                            out_row_q   <= row_q;
                            out_c_q     <= bank_c_addr_i;
                            out_k_q     <= bank_k_addr_i;
                            if (bank_c_addr_i != c_q) begin
                                err_q <= 1'b1;
                            end
                            if (c_q == CAddrWidth'(C - 1)) begin
                                c_q   <= '0;
                                row_q <= row_q + 1'b1;
                                if (row_q == num_rows_q - 1'b1) begin
                                    state_q   <= EncDone;
                                    done_q    <= 1'b1;
                                    encoder_q <= 1'b0;
                                end
                            end else begin
                                c_q <= c_q + 1'b1;
                            end
                        end
                    end
                    EncDone: state_q <= EncIdle;
                    default: state_q <= EncIdle;
                endcase
            end
        end
    end

    assign cfg_ready_o  = cfg_ready_q;
    assign encoder_o    = encoder_q;
    assign out_valid_o  = out_valid_q;
    assign out_row_o    = out_row_q;
    assign out_c_addr_o = out_c_q;
    assign out_k_addr_o = out_k_q;
    assign busy_o       = (state_q != EncIdle);
    assign loaded_o     = loaded_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_halut_encoder_ctrl.sv
// Directed self-checking bench for halut_encoder_ctrl at default parameters
// (C=32, K=16, EncUnits=4, ThreshDepth=128, 512 threshold words).
module tb_halut_encoder_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        load_i, cfg_valid_i, start_i, abort_i;
    logic        cfg_ready_o;
    logic [15:0] cfg_data_i;
    logic [15:0] num_rows_i;
    logic [6:0]  waddr_o [4];
    logic [15:0] wdata_o [4];
    logic        we_o    [4];
    logic        encoder_o;
    logic        bank_valid_i;
    logic [4:0]  bank_c_addr_i;
    logic [3:0]  bank_k_addr_i;
    logic        out_valid_o;
    logic [15:0] out_row_o;
    logic [4:0]  out_c_addr_o;
    logic [3:0]  out_k_addr_o;
    logic        busy_o, loaded_o, done_o, err_o;
    logic [3:0]  weVec;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    always_comb begin
        weVec = '0;
        for (int i = 0; i < 4; i++) weVec[i] = we_o[i];
    end

    halut_encoder_ctrl dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .load_i        (load_i),
        .cfg_valid_i   (cfg_valid_i),
        .cfg_ready_o   (cfg_ready_o),
        .cfg_data_i    (cfg_data_i),
        .start_i       (start_i),
        .num_rows_i    (num_rows_i),
        .abort_i       (abort_i),
        .waddr_o       (waddr_o),
        .wdata_o       (wdata_o),
        .we_o          (we_o),
        .encoder_o     (encoder_o),
        .bank_valid_i  (bank_valid_i),
        .bank_c_addr_i (bank_c_addr_i),
        .bank_k_addr_i (bank_k_addr_i),
        .out_valid_o   (out_valid_o),
        .out_row_o     (out_row_o),
        .out_c_addr_o  (out_c_addr_o),
        .out_k_addr_o  (out_k_addr_o),
        .busy_o        (busy_o),
        .loaded_o      (loaded_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    task automatic test_reset();
        rst_ni = 1'b0; load_i = 0; cfg_valid_i = 0; cfg_data_i = 0; start_i = 0;
        num_rows_i = 0; abort_i = 0; bank_valid_i = 0; bank_c_addr_i = 0; bank_k_addr_i = 0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        vectors++; if ({cfg_ready_o, busy_o, loaded_o, done_o, err_o, encoder_o, out_valid_o} !== 7'b0) begin
            miscompares++; $display("[TB] FAIL reset_flags: got %b expected 0000000",
                {cfg_ready_o, busy_o, loaded_o, done_o, err_o, encoder_o, out_valid_o});
        end
        vectors++; if (weVec !== 4'b0) begin
            miscompares++; $display("[TB] FAIL reset_we: got %b expected 0000", weVec);
        end
        vectors++; if ({out_row_o, out_c_addr_o, out_k_addr_o} !== 25'b0) begin
            miscompares++; $display("[TB] FAIL reset_out: row %0d c %0d k %0d expected 0", out_row_o, out_c_addr_o, out_k_addr_o);
        end
        vectors++; if (waddr_o[0] !== 7'd0 || wdata_o[3] !== 16'd0) begin
            miscompares++; $display("[TB] FAIL reset_wport: waddr0 %0d wdata3 %0d expected 0", waddr_o[0], wdata_o[3]);
        end
    endtask

    task automatic test_start_unloaded();
        @(negedge clk_i); start_i = 1; num_rows_i = 2;
        @(negedge clk_i); start_i = 0;
        vectors++; if (encoder_o !== 1'b0 || busy_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL start_unloaded: encoder %b busy %b expected 0 0", encoder_o, busy_o);
        end
        @(negedge clk_i);
        vectors++; if (done_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL start_unloaded_done: got %b expected 0", done_o);
        end
    endtask

    // Streams 512 words with data = index; toggle drops valid every other cycle.
    task automatic test_load(input bit toggle);
        int sent, cyc, u, a;
        int unitCnt [4];
        bit hs;
        for (int i = 0; i < 4; i++) unitCnt[i] = 0;
        @(negedge clk_i); load_i = 1;
        @(negedge clk_i); load_i = 0;
        vectors++; if (cfg_ready_o !== 1'b1 || loaded_o !== 1'b0 || busy_o !== 1'b1) begin
            miscompares++; $display("[TB] FAIL load_entry: ready %b loaded %b busy %b expected 1 0 1", cfg_ready_o, loaded_o, busy_o);
        end
        sent = 0; cyc = 0;
        while (sent < 512 && cyc < 2000) begin
            cfg_valid_i = toggle ? (cyc % 2 == 0) : 1'b1;
            cfg_data_i  = 16'(sent);
            hs = cfg_valid_i && cfg_ready_o;
            @(negedge clk_i); cyc++;
            for (int i = 0; i < 4; i++) unitCnt[i] += int'(weVec[i]);
            if (hs) begin
                u = sent / 128; a = sent % 128;
                vectors++; if (weVec !== 4'(1 << u) || waddr_o[u] !== 7'(a) || wdata_o[u] !== 16'(sent)) begin
                    miscompares++; $display("[TB] FAIL load_write word %0d: we %b addr %0d data %0d expected we %b addr %0d data %0d",
                        sent, weVec, waddr_o[u], wdata_o[u], 4'(1 << u), a, sent);
                end
                sent++;
            end else begin
                vectors++; if (weVec !== 4'b0) begin
                    miscompares++; $display("[TB] FAIL load_idle_we: got %b expected 0000", weVec);
                end
            end
            vectors++;
            if (sent < 512) begin
                if (cfg_ready_o !== 1'b1 || loaded_o !== 1'b0) begin
                    miscompares++; $display("[TB] FAIL load_ready beat %0d: ready %b loaded %b expected 1 0", sent, cfg_ready_o, loaded_o);
                end
            end else if (cfg_ready_o !== 1'b0 || loaded_o !== 1'b1 || busy_o !== 1'b0) begin
                miscompares++; $display("[TB] FAIL load_end: ready %b loaded %b busy %b expected 0 1 0", cfg_ready_o, loaded_o, busy_o);
            end
        end
        cfg_valid_i = 0;
        vectors++; if (sent != 512) begin
            miscompares++; $display("[TB] FAIL load_timeout: got %0d beats expected 512", sent);
        end
        @(negedge clk_i);
        for (int i = 0; i < 4; i++) unitCnt[i] += int'(weVec[i]);
        for (int i = 0; i < 4; i++) begin
            vectors++; if (unitCnt[i] != 128) begin
                miscompares++; $display("[TB] FAIL load_unit_count %0d: got %0d expected 128", i, unitCnt[i]);
            end
        end
    endtask

    // Bank model returns c = 0..31 per row with k = (3*row + c) % 16; one beat
    // can be corrupted to c+1, and every ninth cycle is a bank bubble.
    task automatic test_run(input int nrows, input int injRow, input int injC);
        int b, cyc, row, c, total;
        bit errExp, gap, last;
        logic [4:0] cSent;
        logic [3:0] kSent;
        @(negedge clk_i); start_i = 1; num_rows_i = 16'(nrows);
        @(negedge clk_i); start_i = 0;
        vectors++; if (encoder_o !== 1'b1 || err_o !== 1'b0 || busy_o !== 1'b1) begin
            miscompares++; $display("[TB] FAIL run_start: encoder %b err %b busy %b expected 1 0 1", encoder_o, err_o, busy_o);
        end
        total = nrows * 32; b = 0; cyc = 0; errExp = 0;
        while (b < total && cyc < 2000) begin
            gap = (cyc % 9 == 8);
            row = b / 32; c = b % 32;
            cSent = (row == injRow && c == injC) ? 5'(c + 1) : 5'(c);
            kSent = 4'((row * 3 + c) % 16);
            bank_valid_i = !gap; bank_c_addr_i = cSent; bank_k_addr_i = kSent;
            @(negedge clk_i); cyc++;
            if (gap) begin
                vectors++; if (out_valid_o !== 1'b0) begin
                    miscompares++; $display("[TB] FAIL run_bubble: out_valid %b expected 0", out_valid_o);
                end
            end else begin
                vectors++; if (out_valid_o !== 1'b1 || out_row_o !== 16'(row) || out_c_addr_o !== cSent || out_k_addr_o !== kSent) begin
                    miscompares++; $display("[TB] FAIL run_result beat %0d: v %b row %0d c %0d k %0d expected 1 %0d %0d %0d",
                        b, out_valid_o, out_row_o, out_c_addr_o, out_k_addr_o, row, cSent, kSent);
                end
                if (cSent != 5'(c)) errExp = 1;
                vectors++; if (err_o !== errExp) begin
                    miscompares++; $display("[TB] FAIL run_err beat %0d: got %b expected %b", b, err_o, errExp);
                end
                b++;
                last = (b == total);
                vectors++; if (done_o !== last || encoder_o !== !last) begin
                    miscompares++; $display("[TB] FAIL run_done beat %0d: done %b encoder %b expected %b %b", b, done_o, encoder_o, last, !last);
                end
            end
        end
        bank_valid_i = 0;
        vectors++; if (b != total) begin
            miscompares++; $display("[TB] FAIL run_timeout: got %0d results expected %0d", b, total);
        end
        @(negedge clk_i);
        vectors++; if (busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== errExp || loaded_o !== 1'b1) begin
            miscompares++; $display("[TB] FAIL run_idle: busy %b done %b err %b loaded %b expected 0 0 %b 1", busy_o, done_o, err_o, loaded_o, errExp);
        end
    endtask

    task automatic test_zero_rows();
        @(negedge clk_i); start_i = 1; num_rows_i = 0;
        @(negedge clk_i); start_i = 0;
        vectors++; if (done_o !== 1'b1 || encoder_o !== 1'b0 || busy_o !== 1'b1 || out_valid_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL zero_rows_done: done %b encoder %b busy %b valid %b expected 1 0 1 0",
                done_o, encoder_o, busy_o, out_valid_o);
        end
        @(negedge clk_i);
        vectors++; if (done_o !== 1'b0 || encoder_o !== 1'b0 || busy_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL zero_rows_idle: done %b encoder %b busy %b expected 0 0 0", done_o, encoder_o, busy_o);
        end
    endtask

    // load_i and start_i together: load must win; then abort with a valid beat pending.
    task automatic test_load_start_collision();
        @(negedge clk_i); load_i = 1; start_i = 1; num_rows_i = 1;
        @(negedge clk_i); load_i = 0; start_i = 0;
        vectors++; if (cfg_ready_o !== 1'b1 || encoder_o !== 1'b0 || loaded_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL collision: ready %b encoder %b loaded %b expected 1 0 0", cfg_ready_o, encoder_o, loaded_o);
        end
        abort_i = 1; cfg_valid_i = 1; cfg_data_i = 16'h00AA;
        @(negedge clk_i); abort_i = 0; cfg_valid_i = 0;
        vectors++; if (busy_o !== 1'b0 || cfg_ready_o !== 1'b0 || weVec !== 4'b0 || loaded_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL collision_abort: busy %b ready %b we %b loaded %b expected 0 0 0000 0",
                busy_o, cfg_ready_o, weVec, loaded_o);
        end
    endtask

    task automatic test_abort_load();
        @(negedge clk_i); load_i = 1;
        @(negedge clk_i); load_i = 0;
        for (int i = 0; i < 200; i++) begin
            cfg_valid_i = 1; cfg_data_i = 16'(i);
            @(negedge clk_i);
        end
        abort_i = 1; cfg_data_i = 16'd200;
        @(negedge clk_i); abort_i = 0; cfg_valid_i = 0;
        vectors++; if (busy_o !== 1'b0 || loaded_o !== 1'b0 || cfg_ready_o !== 1'b0 || weVec !== 4'b0) begin
            miscompares++; $display("[TB] FAIL abort_load: busy %b loaded %b ready %b we %b expected 0 0 0 0000",
                busy_o, loaded_o, cfg_ready_o, weVec);
        end
        start_i = 1; num_rows_i = 1;
        @(negedge clk_i); start_i = 0;
        vectors++; if (encoder_o !== 1'b0 || busy_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL abort_start_ignored: encoder %b busy %b expected 0 0", encoder_o, busy_o);
        end
        @(negedge clk_i);
        vectors++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL abort_no_done: done %b busy %b expected 0 0", done_o, busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_start_unloaded();
        test_load(1'b0);
        test_run(3, -1, 0);
        test_zero_rows();
        test_run(2, 1, 4);
        test_run(1, -1, 0);
        test_load(1'b1);
        test_run(1, -1, 0);
        test_load_start_collision();
        test_abort_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
